// File: rtl/par_link_peer.sv
// par_link_peer: far-end endpoint of the board-to-board parallel byte link.
// Two independent 4-phase req/ack channels on the link side, each backed by a
// first-word-fall-through byte FIFO on the host side. Flow control is by
// withholding ack only, so no byte is ever dropped on the link.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   lk_rx_data/req/ack      inbound link channel (req async, ack registered)
//   lk_tx_data/req/ack      outbound link channel (ack async, data/req registered)
//   rx_byte/valid/pop/count RX FIFO head, not-empty, consume, occupancy
//   tx_byte/push/full/count TX FIFO enqueue, full flag, occupancy
//   link_state              {rx_fsm[1:0], tx_fsm[1:0]} for probe/LED display
module par_link_peer #(
    parameter int unsigned DEPTH_LOG2  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            lk_rx_data,
    input  logic                  lk_rx_req,
    output logic                  lk_rx_ack,
    output logic [7:0]            lk_tx_data,
    output logic                  lk_tx_req,
    input  logic                  lk_tx_ack,
    output logic [7:0]            rx_byte,
    output logic                  rx_valid,
    input  logic                  rx_pop,
    output logic [DEPTH_LOG2:0]   rx_count,
    input  logic [7:0]            tx_byte,
    input  logic                  tx_push,
    output logic                  tx_full,
    output logic [DEPTH_LOG2:0]   tx_count,
    output logic [3:0]            link_state
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_e;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_SETUP = 2'd1,
        T_REQ   = 2'd2,
        T_WAIT  = 2'd3
    } tx_state_e;

    // ---------------------------------------------------------------------
    // Signal declarations
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rx_req_sync_q, rx_req_sync_d;
    logic [SYNC_STAGES-1:0] tx_ack_sync_q, tx_ack_sync_d;
    logic                   rx_req_s;
    logic                   tx_ack_s;

    rx_state_e              rx_state_q, rx_state_d;
    logic                   rx_ack_q, rx_ack_d;

    tx_state_e              tx_state_q, tx_state_d;
    logic                   tx_req_q, tx_req_d;
    logic [7:0]             tx_data_q, tx_data_d;

    logic [7:0]             rx_mem_q [DEPTH];
    logic [PTR_W-1:0]       rx_wr_ptr_q, rx_wr_ptr_d;
    logic [PTR_W-1:0]       rx_rd_ptr_q, rx_rd_ptr_d;
    logic [CNT_W-1:0]       rx_count_q, rx_count_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_full_c;
    logic                   rx_push_c;
    logic                   rx_pop_c;

    logic [7:0]             tx_mem_q [DEPTH];
    logic [PTR_W-1:0]       tx_wr_ptr_q, tx_wr_ptr_d;
    logic [PTR_W-1:0]       tx_rd_ptr_q, tx_rd_ptr_d;
    logic [CNT_W-1:0]       tx_count_q, tx_count_d;
    logic                   tx_full_q, tx_full_d;
    logic [7:0]             tx_head_c;
    logic                   tx_push_c;
    logic                   tx_pop_c;

    // ---------------------------------------------------------------------
    // Input synchronizers: shift in at bit 0, last stage is the clean copy
    // ---------------------------------------------------------------------
    always_comb begin
        rx_req_sync_d = {rx_req_sync_q[SYNC_STAGES-2:0], lk_rx_req};
        tx_ack_sync_d = {tx_ack_sync_q[SYNC_STAGES-2:0], lk_tx_ack};
    end

    assign rx_req_s = rx_req_sync_q[SYNC_STAGES-1];
    assign tx_ack_s = tx_ack_sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // RX handshake FSM: capture once per req pulse, stall by holding ack low
    // ---------------------------------------------------------------------
    always_comb begin
        rx_state_d = rx_state_q;
        rx_ack_d   = rx_ack_q;
        rx_push_c  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                if (rx_req_s && !rx_full_c) begin
                    rx_push_c  = 1'b1;
                    rx_ack_d   = 1'b1;
                    rx_state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (!rx_req_s) begin
                    rx_ack_d   = 1'b0;
                    rx_state_d = R_IDLE;
                end
            end
            default: begin
                rx_ack_d   = 1'b0;
                rx_state_d = R_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // RX FIFO bookkeeping; an internal push is already blocked when full
    // ---------------------------------------------------------------------
    assign rx_full_c = (rx_count_q == CNT_W'(DEPTH));
    assign rx_pop_c  = rx_pop && (rx_count_q != '0);

    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q + PTR_W'(rx_push_c);
        rx_rd_ptr_d = rx_rd_ptr_q + PTR_W'(rx_pop_c);
        rx_count_d  = rx_count_q + CNT_W'(rx_push_c) - CNT_W'(rx_pop_c);
        rx_valid_d  = (rx_count_d != '0);
    end

    // ---------------------------------------------------------------------
    // TX FIFO bookkeeping; a push while full is accepted only alongside the
    // pop that frees the slot (the head byte already sits in lk_tx_data)
    // ---------------------------------------------------------------------
    assign tx_head_c = tx_mem_q[tx_rd_ptr_q];
    assign tx_push_c = tx_push && (!tx_full_q || tx_pop_c);

    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q + PTR_W'(tx_push_c);
        tx_rd_ptr_d = tx_rd_ptr_q + PTR_W'(tx_pop_c);
        tx_count_d  = tx_count_q + CNT_W'(tx_push_c) - CNT_W'(tx_pop_c);
        tx_full_d   = (tx_count_d == CNT_W'(DEPTH));
    end

    // ---------------------------------------------------------------------
    // TX handshake FSM: load head, one setup cycle, raise req, pop on ack
    // ---------------------------------------------------------------------
    always_comb begin
        tx_state_d = tx_state_q;
        tx_req_d   = tx_req_q;
        tx_data_d  = tx_data_q;
        tx_pop_c   = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                // never start while the remote still shows the previous ack
                if ((tx_count_q != '0) && !tx_ack_s) begin
                    tx_data_d  = tx_head_c;
                    tx_state_d = T_SETUP;
                end
            end
            T_SETUP: begin
                tx_req_d   = 1'b1;
                tx_state_d = T_REQ;
            end
            T_REQ: begin
                if (tx_ack_s) begin
                    tx_pop_c   = 1'b1;
                    tx_req_d   = 1'b0;
                    tx_state_d = T_WAIT;
                end
            end
            T_WAIT: begin
                if (!tx_ack_s) begin
                    tx_state_d = T_IDLE;
                end
            end
            default: begin
                tx_req_d   = 1'b0;
                tx_state_d = T_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control and status registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_req_sync_q <= '0;
            tx_ack_sync_q <= '0;
            rx_state_q    <= R_IDLE;
            rx_ack_q      <= 1'b0;
            tx_state_q    <= T_IDLE;
            tx_req_q      <= 1'b0;
            tx_data_q     <= '0;
            rx_wr_ptr_q   <= '0;
            rx_rd_ptr_q   <= '0;
            rx_count_q    <= '0;
            rx_valid_q    <= 1'b0;
            tx_wr_ptr_q   <= '0;
            tx_rd_ptr_q   <= '0;
            tx_count_q    <= '0;
            tx_full_q     <= 1'b0;
        end else begin
            rx_req_sync_q <= rx_req_sync_d;
            tx_ack_sync_q <= tx_ack_sync_d;
            rx_state_q    <= rx_state_d;
            rx_ack_q      <= rx_ack_d;
            tx_state_q    <= tx_state_d;
            tx_req_q      <= tx_req_d;
            tx_data_q     <= tx_data_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_count_q    <= rx_count_d;
            rx_valid_q    <= rx_valid_d;
            tx_wr_ptr_q   <= tx_wr_ptr_d;
            tx_rd_ptr_q   <= tx_rd_ptr_d;
            tx_count_q    <= tx_count_d;
            tx_full_q     <= tx_full_d;
        end
    end

    // FIFO storage: data only, validity is tracked by the pointers/counts
    always_ff @(posedge clk) begin
        if (reset_n && rx_push_c) begin
            rx_mem_q[rx_wr_ptr_q] <= lk_rx_data;
        end
        if (reset_n && tx_push_c) begin
            tx_mem_q[tx_wr_ptr_q] <= tx_byte;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign lk_rx_ack  = rx_ack_q;
    assign lk_tx_req  = tx_req_q;
    assign lk_tx_data = tx_data_q;
    assign rx_byte    = rx_mem_q[rx_rd_ptr_q];
    assign rx_valid   = rx_valid_q;
    assign rx_count   = rx_count_q;
    assign tx_full    = tx_full_q;
    assign tx_count   = tx_count_q;
    assign link_state = {1'b0, rx_state_q, tx_state_q};

endmodule

// File: tb/tb_par_link_peer.sv
// Testbench for par_link_peer: one DUT driven by the bench (with a remote
// receiver model on its TX channel) and a peer instance that is cross-wired
// to the DUT's link for the full-duplex loop.
module tb_par_link_peer;

    localparam int unsigned DL = 3;
    localparam int unsigned CW = DL + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          loop_en;
    logic          emu_en;
    logic          emu_ack;
    logic [7:0]    tb_rx_data;
    logic          tb_rx_req;

    // DUT
    logic [7:0]    d_lk_rx_data, d_lk_tx_data, d_rx_byte, d_tx_byte;
    logic          d_lk_rx_req, d_lk_rx_ack, d_lk_tx_req, d_lk_tx_ack;
    logic          d_rx_valid, d_rx_pop, d_tx_push, d_tx_full;
    logic [CW-1:0] d_rx_count, d_tx_count;
    logic [3:0]    d_link_state;

    // peer
    logic [7:0]    p_lk_rx_data, p_lk_tx_data, p_rx_byte, p_tx_byte;
    logic          p_lk_rx_req, p_lk_rx_ack, p_lk_tx_req, p_lk_tx_ack;
    logic          p_rx_valid, p_rx_pop, p_tx_push, p_tx_full;
    logic [CW-1:0] p_rx_count, p_tx_count;
    logic [3:0]    p_link_state;

    assign d_lk_rx_data = loop_en ? p_lk_tx_data : tb_rx_data;
    assign d_lk_rx_req  = loop_en ? p_lk_tx_req  : tb_rx_req;
    assign d_lk_tx_ack  = loop_en ? p_lk_rx_ack  : emu_ack;
    assign p_lk_rx_data = d_lk_tx_data;
    assign p_lk_rx_req  = loop_en & d_lk_tx_req;
    assign p_lk_tx_ack  = loop_en & d_lk_rx_ack;

    par_link_peer #(.DEPTH_LOG2(DL), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .lk_rx_data(d_lk_rx_data), .lk_rx_req(d_lk_rx_req), .lk_rx_ack(d_lk_rx_ack),
        .lk_tx_data(d_lk_tx_data), .lk_tx_req(d_lk_tx_req), .lk_tx_ack(d_lk_tx_ack),
        .rx_byte(d_rx_byte), .rx_valid(d_rx_valid), .rx_pop(d_rx_pop), .rx_count(d_rx_count),
        .tx_byte(d_tx_byte), .tx_push(d_tx_push), .tx_full(d_tx_full), .tx_count(d_tx_count),
        .link_state(d_link_state)
    );

    par_link_peer #(.DEPTH_LOG2(DL), .SYNC_STAGES(2)) u_peer (
        .clk(clk), .reset_n(reset_n),
        .lk_rx_data(p_lk_rx_data), .lk_rx_req(p_lk_rx_req), .lk_rx_ack(p_lk_rx_ack),
        .lk_tx_data(p_lk_tx_data), .lk_tx_req(p_lk_tx_req), .lk_tx_ack(p_lk_tx_ack),
        .rx_byte(p_rx_byte), .rx_valid(p_rx_valid), .rx_pop(p_rx_pop), .rx_count(p_rx_count),
        .tx_byte(p_tx_byte), .tx_push(p_tx_push), .tx_full(p_tx_full), .tx_count(p_tx_count),
        .link_state(p_link_state)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] rx_sb [$];
    logic [7:0] tx_sb [$];
    logic [7:0] ab_sb [$];
    logic [7:0] ba_sb [$];

    typedef struct {
        logic          push;
        logic [7:0]    data;
        logic          pop;
        logic [CW-1:0] exp_cnt;
        logic          exp_full;
        logic          exp_acc;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx_ack(input logic lvl, input string name);
        int n = 0;
        while (d_lk_rx_ack !== lvl && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(d_lk_rx_ack), 32'(lvl));
    endtask

    task automatic send_rx(input logic [7:0] b);
        tb_rx_data = b;
        tb_rx_req  = 1'b1;
        rx_sb.push_back(b);
        wait_rx_ack(1'b1, "rx_ack_rise");
        tb_rx_req = 1'b0;
        wait_rx_ack(1'b0, "rx_ack_fall");
    endtask

    task automatic pop_rx(input string name);
        logic [7:0] e;
        check({name, "_valid"}, 32'(d_rx_valid), 32'd1);
        if (rx_sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = rx_sb.pop_front();
            check(name, 32'(d_rx_byte), 32'(e));
        end
        d_rx_pop = 1'b1;
        @(negedge clk);
        d_rx_pop = 1'b0;
    endtask

    task automatic wait_tx_drained(input string name);
        int n = 0;
        while ((d_tx_count != '0 || d_link_state[1:0] != 2'd0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check({name, "_count"}, 32'(d_tx_count), 32'd0);
        check({name, "_sb_left"}, 32'(tx_sb.size()), 32'd0);
    endtask

    // Remote receiver model: acks 4 clocks after req, drops ack after req falls
    initial begin : remote_model
        logic       prev_req;
        logic [7:0] cap;
        logic       stable;
        int         dly;
        emu_ack  = 1'b0;
        prev_req = 1'b0;
        cap      = '0;
        stable   = 1'b1;
        dly      = 0;
        forever begin
            @(negedge clk);
            if (!emu_en) begin
                emu_ack  = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (d_lk_tx_req && !prev_req) begin
                    check("tx_req_rise_ack_low", 32'(emu_ack), 32'd0);
                    cap    = d_lk_tx_data;
                    stable = 1'b1;
                    dly    = 0;
                end
                if (d_lk_tx_req && !emu_ack) begin
                    if (d_lk_tx_data !== cap) stable = 1'b0;
                    dly++;
                    if (dly == 4) begin
                        emu_ack = 1'b1;
                        check("tx_data_stable", 32'(stable), 32'd1);
                        if (tx_sb.size() == 0) check("tx_unexpected_byte", 32'(cap), 32'h100);
                        else check("tx_byte_order", 32'(cap), 32'(tx_sb.pop_front()));
                    end
                end else if (emu_ack && !d_lk_tx_req) begin
                    emu_ack = 1'b0;
                end
                prev_req = d_lk_tx_req;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic seen;
        int   n;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{1'b1, 8'(8'h10 + i), 1'b0, CW'(i + 1), (i == 7), 1'b1};
        end
        vecs[8] = '{1'b1, 8'hFF, 1'b0, CW'(8), 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b1, CW'(8), 1'b1, 1'b0};

        reset_n = 1'b0; loop_en = 1'b0; emu_en = 1'b0;
        tb_rx_data = '0; tb_rx_req = 1'b0;
        d_rx_pop = 1'b0; d_tx_push = 1'b0; d_tx_byte = '0;
        p_rx_pop = 1'b0; p_tx_push = 1'b0; p_tx_byte = '0;

        // reset values
        repeat (3) @(negedge clk);
        check("rst_rx_ack", 32'(d_lk_rx_ack), 32'd0);
        check("rst_tx_req", 32'(d_lk_tx_req), 32'd0);
        check("rst_tx_data", 32'(d_lk_tx_data), 32'd0);
        check("rst_rx_valid", 32'(d_rx_valid), 32'd0);
        check("rst_rx_count", 32'(d_rx_count), 32'd0);
        check("rst_tx_count", 32'(d_tx_count), 32'd0);
        check("rst_tx_full", 32'(d_tx_full), 32'd0);
        check("rst_link_state", 32'(d_link_state), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // single byte in: exact ack latency both edges
        tb_rx_data = 8'hA5;
        tb_rx_req  = 1'b1;
        rx_sb.push_back(8'hA5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rx_ack_rise_latency", 32'(d_lk_rx_ack), 32'(k == 3));
        end
        tb_rx_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("rx_ack_fall_latency", 32'(d_lk_rx_ack), 32'(k < 3));
        end
        check("rx_single_count", 32'(d_rx_count), 32'd1);
        pop_rx("rx_single_byte");
        check("rx_single_count_after_pop", 32'(d_rx_count), 32'd0);
        check("rx_single_valid_after_pop", 32'(d_rx_valid), 32'd0);

        // RX backpressure
        for (int b = 1; b <= 8; b++) send_rx(8'(b));
        check("rx_bp_count_full", 32'(d_rx_count), 32'd8);
        tb_rx_data = 8'h09;
        tb_rx_req  = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (d_lk_rx_ack) seen = 1'b1;
        end
        check("rx_bp_no_ack_when_full", 32'(seen), 32'd0);
        check("rx_bp_count_held", 32'(d_rx_count), 32'd8);
        // rx_sb order: 01..08 then 09 once it is accepted
        rx_sb.push_back(8'h09);
        pop_rx("rx_bp_pop");
        wait_rx_ack(1'b1, "rx_bp_late_ack");
        tb_rx_req = 1'b0;
        wait_rx_ack(1'b0, "rx_bp_late_ack_fall");
        for (int b = 2; b <= 9; b++) pop_rx("rx_bp_order");
        check("rx_bp_count_empty", 32'(d_rx_count), 32'd0);

        // TX ordering with remote model
        emu_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_tx_push = 1'b1;
            d_tx_byte = 8'(8'h3C + i);
            tx_sb.push_back(8'(8'h3C + i));
            @(negedge clk);
        end
        d_tx_push = 1'b0;
        check("tx_order_count3", 32'(d_tx_count), 32'd3);
        wait_tx_drained("tx_order_drain");
        emu_en = 1'b0;
        repeat (2) @(negedge clk);

        // TX full table (remote never acks, so no pops)
        for (int i = 0; i < 10; i++) begin
            d_tx_push = vecs[i].push;
            d_tx_byte = vecs[i].data;
            d_rx_pop  = vecs[i].pop;
            if (vecs[i].exp_acc) tx_sb.push_back(vecs[i].data);
            @(negedge clk);
            d_tx_push = 1'b0;
            d_rx_pop  = 1'b0;
            check("tbl_tx_count", 32'(d_tx_count), 32'(vecs[i].exp_cnt));
            check("tbl_tx_full", 32'(d_tx_full), 32'(vecs[i].exp_full));
            check("tbl_rx_count", 32'(d_rx_count), 32'd0);
        end

        // push accepted in the pop cycle while full
        emu_en = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!emu_ack && n < 60);
        check("tx_emu_ack_seen", 32'(emu_ack), 32'd1);
        @(negedge clk);
        @(negedge clk);
        check("tx_req_before_pop", 32'(d_lk_tx_req), 32'd1);
        d_tx_push = 1'b1;
        d_tx_byte = 8'hEE;
        tx_sb.push_back(8'hEE);
        @(negedge clk);
        d_tx_push = 1'b0;
        check("tx_pushpop_req_low", 32'(d_lk_tx_req), 32'd0);
        check("tx_pushpop_count", 32'(d_tx_count), 32'd8);
        check("tx_pushpop_full", 32'(d_tx_full), 32'd1);
        wait_tx_drained("tx_full_drain");
        emu_en = 1'b0;
        repeat (2) @(negedge clk);

        // reset mid-handshake
        d_tx_push = 1'b1;
        d_tx_byte = 8'h77;
        @(negedge clk);
        d_tx_push = 1'b0;
        tb_rx_data = 8'h99;
        tb_rx_req  = 1'b1;
        n = 0;
        while (!(d_lk_tx_req && d_lk_rx_ack) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("mid_hs_both_high", 32'(d_lk_tx_req & d_lk_rx_ack), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_req", 32'(d_lk_tx_req), 32'd0);
        check("mid_rst_rx_ack", 32'(d_lk_rx_ack), 32'd0);
        check("mid_rst_rx_count", 32'(d_rx_count), 32'd0);
        check("mid_rst_tx_count", 32'(d_tx_count), 32'd0);
        check("mid_rst_link_state", 32'(d_link_state), 32'd0);
        tb_rx_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        send_rx(8'h5A);
        pop_rx("post_rst_rx");
        check("post_rst_tx_idle", 32'(d_lk_tx_req), 32'd0);

        // full-duplex loop
        loop_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d_tx_push = 1'b1; d_tx_byte = 8'(8'h80 + i);
            p_tx_push = 1'b1; p_tx_byte = 8'(8'hC0 + i);
            ab_sb.push_back(8'(8'h80 + i));
            ba_sb.push_back(8'(8'hC0 + i));
            @(negedge clk);
        end
        d_tx_push = 1'b0;
        p_tx_push = 1'b0;
        n = 0;
        while (!(d_rx_count == CW'(8) && p_rx_count == CW'(8)) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("loop_peer_rx_count", 32'(p_rx_count), 32'd8);
        check("loop_dut_rx_count", 32'(d_rx_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (ab_sb.size() != 0) check("loop_a_to_b", 32'(p_rx_byte), 32'(ab_sb.pop_front()));
            if (ba_sb.size() != 0) check("loop_b_to_a", 32'(d_rx_byte), 32'(ba_sb.pop_front()));
            d_rx_pop = 1'b1;
            p_rx_pop = 1'b1;
            @(negedge clk);
            d_rx_pop = 1'b0;
            p_rx_pop = 1'b0;
        end
        check("loop_peer_rx_empty", 32'(p_rx_count), 32'd0);
        check("loop_dut_rx_empty", 32'(d_rx_count), 32'd0);
        check("loop_tx_counts", 32'(d_tx_count) + 32'(p_tx_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/par_link_peer.md
Name: par_link_peer

Overview:
- Far-end endpoint of the board-to-board GPIO parallel byte link: accepts bytes a CPU board drives on its parallel output lines and drives bytes back into that board's parallel input lines.
- Link side: two independent 4-phase req/ack channels, with all link inputs synchronized.
- Host side: FIFO-buffered byte streams, usable by a second board, a UART bridge or a test harness.
- Flow control is by ack withholding only; no byte is ever dropped.

Parameters:
- DEPTH_LOG2, 3, log2 of each FIFO depth (default 8 entries per direction).
- SYNC_STAGES, 2, flop stages on lk_rx_req and lk_tx_ack (>=2).

Ports:
- clk  input  1  system clock (27 MHz)
- reset_n  input  1  synchronous, active-low reset
- lk_rx_data  input  8  byte from remote sender, stable while lk_rx_req high
- lk_rx_req  input  1  remote sender data-valid (async)
- lk_rx_ack  output  1  byte captured, held until lk_rx_req falls
- lk_tx_data  output  8  byte to remote receiver
- lk_tx_req  output  1  lk_tx_data valid
- lk_tx_ack  input  1  remote receiver captured byte (async)
- rx_byte  output  8  RX FIFO head (first-word fall-through)
- rx_valid  output  1  RX FIFO not empty
- rx_pop  input  1  consume rx_byte
- rx_count  output  DEPTH_LOG2+1  RX occupancy
- tx_byte  input  8  byte to send
- tx_push  input  1  enqueue tx_byte
- tx_full  output  1  TX FIFO full
- tx_count  output  DEPTH_LOG2+1  TX occupancy
- link_state  output  4  {rx_fsm[1:0], tx_fsm[1:0]} for probe/LED display

Behaviour:
- Reset (reset_n low at a clk edge):
  - FIFOs emptied; both FSMs go to IDLE; synchronizer flops cleared.
  - lk_rx_ack=0, lk_tx_req=0, lk_tx_data=0, rx_valid=0, rx_count=0, tx_count=0, tx_full=0, link_state=0.
  - Reset mid-handshake aborts immediately: req/ack drop the next cycle and the in-flight TX byte is discarded with the FIFO.
- Synchronization:
  - lk_rx_req and lk_tx_ack pass through SYNC_STAGES flops; the last stage is named *_s.
  - lk_rx_data is sampled raw; it is qualified by protocol stability.
- RX FSM, encoding R_IDLE=0, R_ACK=1:
  - R_IDLE: if rx_req_s=1 and RX not full, write lk_rx_data to RX FIFO, set lk_rx_ack=1, go to R_ACK.
  - R_IDLE with RX full: ack stays 0 and the FSM waits; the remote sender stalls.
  - R_ACK: hold ack; when rx_req_s=0, clear ack and go to R_IDLE.
  - Latency: lk_rx_req rise to lk_rx_ack rise is SYNC_STAGES+1 clocks when not full.
  - Exactly one push per req pulse.
- TX FSM, encoding T_IDLE=0, T_SETUP=1, T_REQ=2, T_WAIT=3:
  - T_IDLE: if TX not empty and tx_ack_s=0, load lk_tx_data from head, go to T_SETUP.
  - T_SETUP: one cycle of data setup; then lk_tx_req=1, go to T_REQ.
  - T_REQ: when tx_ack_s=1, pop TX FIFO, lk_tx_req=0, go to T_WAIT.
  - T_WAIT: when tx_ack_s=0, go to T_IDLE.
  - lk_tx_data is held from T_SETUP until the next load.
  - Minimum back-to-back period is 2*SYNC_STAGES+3 clocks plus remote delay.
- FIFOs:
  - Circular buffers with DEPTH_LOG2-bit pointers that wrap naturally; count is DEPTH_LOG2+1 bits.
  - Full when count=2^DEPTH_LOG2.
  - rx_pop with rx_valid=0 is ignored.
  - tx_push with tx_full=1 is ignored; the byte is lost and count is unchanged.
  - Simultaneous push and pop on the same FIFO: both occur, count unchanged, and this holds even when the FIFO is full (RX internal push is blocked when full, so only the pop occurs) or empty (pop ignored, push occurs).
  - rx_byte and rx_valid update the cycle after a write into an empty FIFO.
- RX and TX channels are fully independent; simultaneous activity is allowed.

Test Plan:
- Single byte in: reset, drive lk_rx_data=8'hA5 then lk_rx_req=1 → lk_rx_ack=1 exactly 3 clocks later (SYNC_STAGES=2). Drop req → ack=0 3 clocks later. rx_valid=1, rx_byte=A5, rx_count=1. rx_pop → rx_count=0.
- RX backpressure: send 8 bytes 01..08 with no pops, then a 9th byte 09 → 9th req gets no ack while rx_count=8. One rx_pop → 09 acked. Pops return 02..09 in order.
- TX ordering: push 3C, 3D, 3E; emulate remote ack after 4 clocks → lk_tx_data sequence 3C, 3D, 3E, each stable through lk_tx_req high. tx_count 3→0. lk_tx_req never rises while lk_tx_ack is high.
- TX full and push/pop edge: fill 8 bytes, push 8'hFF → ignored, tx_full=1, count=8. Push during the T_REQ pop cycle → accepted, count stays 8.
- Reset mid-handshake: assert reset_n=0 while lk_tx_req=1 and lk_rx_ack=1 → next cycle both 0, counts 0, link_state=0. After release, a new RX byte 8'h5A is received normally.
- Full-duplex loop: cross-connect two instances' lk_tx_* to lk_rx_* → 8 bytes pushed on each side arrive intact and in order at the opposite rx_byte.
